satd_hadamard_engine: RTL and testbench
=======================================

Name: satd_hadamard_engine

Overview:
- Parametrised successor to the fixed 4x4 SATD unit in the FME path.
- Accepts one 4-pixel row of current and reference pixels per cycle and forms signed residuals.
- Applies a row then column 4-point Hadamard through an internal transpose buffer, and sums absolute coefficients.
- Accumulates the cost over a programmable number of 4x4 sub-blocks, so one run covers 4x4 up to 16x16 partitions, with valid/ready handshakes on input and output.

Parameters:
- PIX_W, 8, pixel bit depth.
- ACC_W, 20, width of the accumulated cost output; saturating.
- MAX_BLK, 16, maximum 4x4 sub-blocks per run; sets the width of num_blk (clog2(MAX_BLK+1)).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- num_blk  in  clog2(MAX_BLK+1)  sub-blocks in this run; latched on start. Value 0 is treated as 1; values above MAX_BLK clamp to MAX_BLK.
- sad_mode  in  1  latched on start. 1 = plain SAD of residuals; 0 = Hadamard SATD.
- abort  in  1  synchronous cancel; overrides everything except reset.
- in_valid  in  1  row valid.
- in_ready  out  1  high only in LOAD.
- cur_row  in  4*PIX_W  current pixels; pixel k at bits [k*PIX_W +: PIX_W].
- ref_row  in  4*PIX_W  reference pixels, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- cost  out  ACC_W  accumulated cost.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, busy=0, cost=0; row count, block count and accumulator cleared.
- States: IDLE, LOAD, XFORM, DONE.
- IDLE:
  - start → LOAD; latch num_blk and sad_mode; clear accumulator and both counters.
  - start while not in IDLE is ignored.
- LOAD:
  - A row transfers when in_valid && in_ready.
  - Residual r[k] = cur[k] - ref[k], signed, PIX_W+1 bits.
  - SATD mode: row 1-D Hadamard (a+b+c+d, a+b-c-d, a-b-c+d, a-b+c-d), PIX_W+3 bits signed, written to transpose buffer row row_cnt.
  - SAD mode: |r[k]| stored in the buffer instead.
  - After row 3 transfers: row_cnt wraps to 0, state → XFORM, in_ready drops the next cycle.
- XFORM (single cycle, in_ready=0):
  - SATD mode: column Hadamard on all 4 buffer columns (PIX_W+5 bits signed); blk_cost = (sum of 16 |coef|) >> 1, truncating.
  - SAD mode: blk_cost = sum of 16 buffer entries.
  - acc <= min(acc + blk_cost, 2^ACC_W-1), saturating with no wrap.
  - If blk_cnt == num_blk-1 → DONE; else blk_cnt++ → LOAD.
- DONE:
  - out_valid=1 and cost=acc, both held stable while out_ready=0.
  - out_valid && out_ready → IDLE, out_valid=0 next cycle. cost keeps its last value until the next start.
- Latency: 2 cycles from the final row handshake to out_valid.
- Throughput: one 4x4 block per 5 cycles.
- Row stall: in_valid low in LOAD inserts bubbles; the buffer and row_cnt hold.
- abort in any state → IDLE next cycle. It clears counters and out_valid. A row presented in the same cycle as abort is discarded.
- start and abort in the same cycle: abort wins and the state stays IDLE.

Decomposition:
- Package satd_pkg holds:
  - State enum.
  - Width helper functions for residual, row, column and block-cost widths, derived from PIX_W.
  - Hadamard sign constants.
- Sub-module hadamard4: combinational 4-point butterfly parametrised by input width, output 2 bits wider. Instantiated once for rows and four times for columns.

Test Plan:
- All rows with cur=ref=0x80, num_blk=1, SATD → cost=0, out_valid 2 cycles after row 3.
- Single residual +1 at (0,0), rest 0, SATD → cost=8 (16 coefficients of magnitude 1, >>1); same stimulus with sad_mode=1 → cost=1.
- Constant residual +10, num_blk=4, SATD → each block DC=160 → 80, final cost=320; SAD mode → 640.
- ACC_W=10, residual 255 everywhere, num_blk=1, SATD → raw 2040 saturates to cost=1023.
- in_valid toggled 1,0,1,0 in LOAD, then out_ready held low 5 cycles in DONE → cost correct, cost/out_valid stable, a start pulse during DONE is ignored.
- abort asserted after row 2 of block 1 with num_blk=2 → IDLE next cycle, in_ready=0, out_valid never asserted; a new start then yields a correct independent result.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared types, width helpers and butterfly sign table for the SATD engine.
package satd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_XFORM,
        S_DONE
    } state_t;

    function automatic int res_w(input int pix_w);
        return pix_w + 1;
    endfunction

    function automatic int row_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int col_w(input int pix_w);
        return pix_w + 5;
    endfunction

    // Sum of 16 column magnitudes, each below 2^(pix_w+4)
    function automatic int blk_w(input int pix_w);
        return pix_w + 8;
    endfunction

    // Bit j of entry k set means input j is subtracted for output k
    localparam logic [3:0][3:0] HAD_NEG = {4'b1010, 4'b0110, 4'b1100, 4'b0000};

endpackage

// File: rtl/hadamard4.sv
// Combinational 4-point Hadamard butterfly; output is two bits wider than input.
module hadamard4 #(
    parameter int IN_W = 9
) (
    input  logic [4*IN_W-1:0]     x,
    output logic [4*(IN_W+2)-1:0] y
);
    import satd_pkg::*;

    localparam int OUT_W = IN_W + 2;

    logic signed [OUT_W-1:0] xe [4];
    logic signed [OUT_W-1:0] s  [4];

    always_comb begin
        y = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            xe[j] = OUT_W'($signed(x[j*IN_W +: IN_W]));
        end
        for (int unsigned k = 0; k < 4; k++) begin
            s[k] = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                if (HAD_NEG[k][j]) s[k] = s[k] - xe[j];
                else               s[k] = s[k] + xe[j];
            end
            y[k*OUT_W +: OUT_W] = s[k];
        end
    end

endmodule

// File: rtl/satd_hadamard_engine.sv
// Multi-block 4x4 SATD/SAD cost engine: row butterfly on load, column butterfly
// and absolute sum in a single transform cycle, saturating accumulation.
module satd_hadamard_engine #(
    parameter int PIX_W   = 8,
    parameter int ACC_W   = 20,
    parameter int MAX_BLK = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_BLK+1)-1:0]   num_blk,
    input  logic                           sad_mode,
    input  logic                           abort,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4*PIX_W-1:0]             cur_row,
    input  logic [4*PIX_W-1:0]             ref_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               cost,
    output logic                           busy
);
    import satd_pkg::*;

    localparam int NB_W  = $clog2(MAX_BLK + 1);
    localparam int RES_W = res_w(PIX_W);
    localparam int ROW_W = row_w(PIX_W);
    localparam int COL_W = col_w(PIX_W);
    localparam int BLK_W = blk_w(PIX_W);
    localparam int SUM_W = ((ACC_W > BLK_W) ? ACC_W : BLK_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t              state;
    logic [1:0]          row_cnt;
    logic [NB_W-1:0]     blk_cnt;
    logic [NB_W-1:0]     last_blk;
    logic [NB_W-1:0]     blk_lim;
    logic                sad_q;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [SUM_W-1:0]    acc_sum;

    logic signed [RES_W-1:0] res     [4];
    logic [PIX_W-1:0]        res_abs [4];
    logic [4*RES_W-1:0]      res_packed;
    logic [4*ROW_W-1:0]      row_h;
    logic [ROW_W-1:0]        wr_row  [4];

    logic signed [ROW_W-1:0] tbuf    [4][4];
    logic [4*ROW_W-1:0]      col_in  [4];
    logic [4*COL_W-1:0]      col_out [4];

    logic signed [COL_W-1:0] coef;
    logic [COL_W-1:0]        mag;
    logic [BLK_W-1:0]        satd_sum;
    logic [BLK_W-1:0]        sad_sum;
    logic [BLK_W-1:0]        blk_cost;

    always_comb begin
        res_packed = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            res[k] = $signed({1'b0, cur_row[k*PIX_W +: PIX_W]})
                   - $signed({1'b0, ref_row[k*PIX_W +: PIX_W]});
            res_abs[k] = res[k][RES_W-1] ? PIX_W'(-res[k]) : PIX_W'(res[k]);
            res_packed[k*RES_W +: RES_W] = res[k];
        end
    end

    hadamard4 #(.IN_W(RES_W)) u_row_had (
        .x (res_packed),
        .y (row_h)
    );

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            wr_row[k] = sad_q ? ROW_W'(res_abs[k]) : row_h[k*ROW_W +: ROW_W];
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid && !abort) begin
            for (int unsigned k = 0; k < 4; k++) begin
                tbuf[row_cnt][k] <= wr_row[k];
            end
        end
    end

    // Column j gathers buffer entry (i,j) into slot i of the butterfly input
    always_comb begin
        for (int unsigned j = 0; j < 4; j++) begin
            col_in[j] = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                col_in[j][i*ROW_W +: ROW_W] = tbuf[i][j];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_col
        hadamard4 #(.IN_W(ROW_W)) u_col_had (
            .x (col_in[g]),
            .y (col_out[g])
        );
    end

    always_comb begin
        satd_sum = '0;
        sad_sum  = '0;
        coef     = '0;
        mag      = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                coef     = $signed(col_out[j][i*COL_W +: COL_W]);
                mag      = coef[COL_W-1] ? -coef : coef;
                satd_sum = satd_sum + BLK_W'(mag);
                sad_sum  = sad_sum + BLK_W'($unsigned(tbuf[i][j]));
            end
        end
        blk_cost = sad_q ? sad_sum : (satd_sum >> 1);
    end

    always_comb begin
        acc_sum  = SUM_W'(acc) + SUM_W'(blk_cost);
        acc_next = (acc_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        if (num_blk == '0)                 blk_lim = NB_W'(1);
        else if (int'(num_blk) > MAX_BLK)  blk_lim = NB_W'(MAX_BLK);
        else                               blk_lim = num_blk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cost      <= '0;
            row_cnt   <= '0;
            blk_cnt   <= '0;
            last_blk  <= '0;
            sad_q     <= 1'b0;
            acc       <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            row_cnt   <= '0;
            blk_cnt   <= '0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        last_blk <= blk_lim - NB_W'(1);
                        sad_q    <= sad_mode;
                        acc      <= '0;
                        cost     <= '0;
                        row_cnt  <= '0;
                        blk_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            state    <= S_XFORM;
                            in_ready <= 1'b0;
                        end
                    end
                end
                S_XFORM: begin
                    acc <= acc_next;
                    if (blk_cnt == last_blk) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        cost      <= acc_next;
                    end else begin
                        blk_cnt  <= blk_cnt + NB_W'(1);
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_satd_hadamard_engine.sv
// Directed bench for satd_hadamard_engine with hand-computed SATD/SAD costs.
module tb_satd_hadamard_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_blk;
    logic        sad_mode;
    logic        abort;
    logic        in_valid;
    logic [31:0] cur_row;
    logic [31:0] ref_row;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [19:0] cost;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [9:0]  cost_s;

    logic [7:0]  cur_m [4][4];
    logic [7:0]  ref_m [4][4];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    satd_hadamard_engine #(.PIX_W(8), .ACC_W(20), .MAX_BLK(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blk(num_blk), .sad_mode(sad_mode),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .cur_row(cur_row),
        .ref_row(ref_row), .out_valid(out_valid), .out_ready(out_ready), .cost(cost),
        .busy(busy)
    );

    satd_hadamard_engine #(.PIX_W(8), .ACC_W(10), .MAX_BLK(16)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .num_blk(num_blk), .sad_mode(sad_mode),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready_s), .cur_row(cur_row),
        .ref_row(ref_row), .out_valid(out_valid_s), .out_ready(out_ready), .cost(cost_s),
        .busy(busy_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_const(input logic [7:0] c, input logic [7:0] r);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                cur_m[i][j] = c;
                ref_m[i][j] = r;
            end
    endtask

    task automatic drive_row(input int r);
        for (int k = 0; k < 4; k++) begin
            cur_row[k*8 +: 8] = cur_m[r][k];
            ref_row[k*8 +: 8] = ref_m[r][k];
        end
    endtask

    task automatic load_block();
        for (int r = 0; r < 4; r++) begin
            drive_row(r);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    // Leaves the bench in the transform cycle of the final block
    task automatic send_run(input logic [4:0] n, input int nblocks, input logic sad);
        num_blk  = n;
        sad_mode = sad;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < nblocks; b++) begin
            load_block();
            if (b != nblocks - 1) step();
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; num_blk = '0; sad_mode = 1'b0; abort = 1'b0;
        in_valid = 1'b0; cur_row = '0; ref_row = '0; out_ready = 1'b0;
        step();
        step();
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
        compared++;
        if (cost !== 20'd0) begin mismatched++; $display("FAIL reset_cost: got %0d expected 0", cost); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_zero();
        set_const(8'h80, 8'h80);
        send_run(5'd1, 1, 1'b0);
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL zero_latency_early: got %b expected 0", out_valid); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL zero_in_ready_xform: got %b expected 0", in_ready); end
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL zero_busy: got %b expected 1", busy); end
        step();
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL zero_latency_valid: got %b expected 1", out_valid); end
        compared++;
        if (cost !== 20'd0) begin mismatched++; $display("FAIL zero_cost: got %0d expected 0", cost); end
        consume();
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL zero_valid_clear: got %b expected 0", out_valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL zero_busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_impulse();
        set_const(8'h80, 8'h80);
        cur_m[0][0] = 8'h81;
        send_run(5'd1, 1, 1'b0);
        step();
        compared++;
        if (cost !== 20'd8) begin mismatched++; $display("FAIL impulse_satd_cost: got %0d expected 8", cost); end
        consume();
        send_run(5'd1, 1, 1'b1);
        step();
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL impulse_sad_valid: got %b expected 1", out_valid); end
        compared++;
        if (cost !== 20'd1) begin mismatched++; $display("FAIL impulse_sad_cost: got %0d expected 1", cost); end
        consume();
        step();
        compared++;
        if (cost !== 20'd1) begin mismatched++; $display("FAIL impulse_cost_held_idle: got %0d expected 1", cost); end
    endtask

    task automatic test_const_multi();
        set_const(8'h8A, 8'h80);
        send_run(5'd4, 4, 1'b0);
        step();
        compared++;
        if (cost !== 20'd320) begin mismatched++; $display("FAIL const4_satd_cost: got %0d expected 320", cost); end
        consume();
        send_run(5'd4, 4, 1'b1);
        step();
        compared++;
        if (cost !== 20'd640) begin mismatched++; $display("FAIL const4_sad_cost: got %0d expected 640", cost); end
        consume();
    endtask

    task automatic test_saturation();
        set_const(8'hFF, 8'h00);
        send_run(5'd1, 1, 1'b0);
        step();
        compared++;
        if (out_valid_s !== 1'b1) begin mismatched++; $display("FAIL sat_valid: got %b expected 1", out_valid_s); end
        compared++;
        if (cost_s !== 10'd1023) begin mismatched++; $display("FAIL sat_cost_acc10: got %0d expected 1023", cost_s); end
        compared++;
        if (cost !== 20'd2040) begin mismatched++; $display("FAIL sat_cost_acc20: got %0d expected 2040", cost); end
        consume();
    endtask

    task automatic test_num_blk_bounds();
        set_const(8'h81, 8'h80);
        send_run(5'd0, 1, 1'b1);
        step();
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL nblk0_valid: got %b expected 1", out_valid); end
        compared++;
        if (cost !== 20'd16) begin mismatched++; $display("FAIL nblk0_cost: got %0d expected 16", cost); end
        consume();
        send_run(5'd17, 16, 1'b1);
        step();
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL nblk17_valid: got %b expected 1", out_valid); end
        compared++;
        if (cost !== 20'd256) begin mismatched++; $display("FAIL nblk17_cost: got %0d expected 256", cost); end
        consume();
    endtask

    task automatic test_stall();
        set_const(8'h8A, 8'h80);
        num_blk  = 5'd1;
        sad_mode = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < 4; r++) begin
            drive_row(r);
            in_valid = 1'b1;
            step();
            if (r < 2) begin
                in_valid = 1'b0;
                cur_row  = '1;
                step();
                compared++;
                if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stall_in_ready_row%0d: got %b expected 1", r, in_ready); end
            end
        end
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (out_valid !== 1'b1) begin mismatched++; $display("FAIL stall_hold_valid_%0d: got %b expected 1", i, out_valid); end
            compared++;
            if (cost !== 20'd80) begin mismatched++; $display("FAIL stall_hold_cost_%0d: got %0d expected 80", i, cost); end
            start = (i == 1);
            if (i < 5) step();
        end
        start = 1'b0;
        consume();
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL stall_busy_after: got %b expected 0", busy); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_start_ignored: got %b expected 0", in_ready); end
    endtask

    task automatic test_abort();
        logic seen_ov;
        set_const(8'h8A, 8'h80);
        num_blk  = 5'd2;
        sad_mode = 1'b0;
        start    = 1'b1;
        step();
        start = 1'b0;
        load_block();
        step();
        for (int r = 0; r < 3; r++) begin
            drive_row(r);
            in_valid = 1'b1;
            step();
        end
        drive_row(3);
        in_valid = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL abort_in_ready: got %b expected 0", in_ready); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b expected 0", busy); end
        seen_ov = out_valid;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_ov = seen_ov | out_valid;
        end
        compared++;
        if (seen_ov !== 1'b0) begin mismatched++; $display("FAIL abort_no_out_valid: got %b expected 0", seen_ov); end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("FAIL start_abort_in_ready: got %b expected 0", in_ready); end
        set_const(8'h80, 8'h80);
        cur_m[0][0] = 8'h81;
        send_run(5'd1, 1, 1'b0);
        step();
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("FAIL post_abort_valid: got %b expected 1", out_valid); end
        compared++;
        if (cost !== 20'd8) begin mismatched++; $display("FAIL post_abort_cost: got %0d expected 8", cost); end
        consume();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_impulse();
        test_const_multi();
        test_saturation();
        test_num_blk_bounds();
        test_stall();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
